// File: rtl/arbiter_n_pkg.sv
// arbiter_n_pkg: shared types and helpers for the N-master split-capable bus arbiter.
// Contents: FSM state enum, arbitration mode constants, mux-select width helper.
// No ports; imported by arbiter_n and arb_pick.
package arbiter_n_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index width for n items, never narrower than one bit.
  function automatic int calc_msel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational request picker, fixed priority or rotating start point.
// Ports: req (request vector), start (rotation origin, used when mode=1), mode (1 = round robin),
//        vld (any request found), idx (index of the winner). Zero latency, no state.
module arb_pick
  import arbiter_n_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int MSEL_W      = calc_msel_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MSEL_W-1:0]      start,
  input  logic                   mode,
  output logic                   vld,
  output logic [MSEL_W-1:0]      idx
);

  int base;
  int j;

  // Scan NUM_MASTERS positions beginning at base; the first set bit wins.
  // start is always below NUM_MASTERS, so a single subtraction wraps.
  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    j    = 0;
    base = mode ? int'(start) : 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      j = base + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (!vld && req[j]) begin
        vld = 1'b1;
        idx = MSEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/arbiter_n.sv
// arbiter_n: N-master bus arbiter with one outstanding split transaction, fixed or round-robin.
// Ports: clk, rstn (async active-low); breq per master; sready (non-split slaves), sreadysp/ssplit
//        (split-capable slave); outputs bgrant (one-hot), msel, msplit (parked master), split_grant pulse.
// Latency one cycle, all outputs registered. Optional macro ARB_TIMEOUT_EN bounds tenure to MAX_TENURE cycles.
module arbiter_n
  import arbiter_n_pkg::*;
#(
  parameter int  NUM_MASTERS = 2,
  parameter int  NUM_SLAVES  = 2,
  parameter int  ARB_MODE    = ARB_FIXED,
  parameter int  MAX_TENURE  = 16,
  localparam int MSEL_W      = calc_msel_w(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] breq,
  input  logic [NUM_SLAVES-1:0]  sready,
  input  logic                   sreadysp,
  input  logic                   ssplit,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [MSEL_W-1:0]      msel,
  output logic [NUM_MASTERS-1:0] msplit,
  output logic                   split_grant
);

  arb_state_t             state, state_nxt;
  logic                   split_pending, split_pending_nxt;
  logic [MSEL_W-1:0]      split_owner, split_owner_nxt;
  logic [MSEL_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic [MSEL_W-1:0]      msel_nxt;
  logic [NUM_MASTERS-1:0] bgrant_nxt, msplit_nxt;
  logic                   split_grant_nxt;

  logic [NUM_MASTERS-1:0] own_oh, split_mask, elig, pick_req;
  logic                   busy, revoke, bus_free, resume, pick_vld, grant_now;
  logic [MSEL_W-1:0]      pick_idx, grant_idx;

  // msel doubles as the owner register: it always names the last granted master.
  always_comb begin
    own_oh        = '0;
    own_oh[msel]  = 1'b1;
    split_mask    = '0;
    if (split_pending) split_mask[split_owner] = 1'b1;
  end

  assign busy     = (state == ARB_BUSY);
  // The parked master may not win through the normal path; it only returns via resume.
  assign elig     = breq & ~split_mask;
  // On a tenure revoke the current owner sits out this one decision.
  assign pick_req = revoke ? (elig & ~own_oh) : elig;
  assign bus_free = !busy || !breq[msel] || revoke;
  assign resume   = split_pending && sreadysp && !ssplit;

`ifdef ARB_TIMEOUT_EN
  localparam int              TEN_W    = calc_msel_w(MAX_TENURE);
  localparam logic [TEN_W-1:0] TEN_LAST = TEN_W'(MAX_TENURE - 1);

  logic [TEN_W-1:0] tenure;

  assign revoke = busy && (tenure == TEN_LAST) && (|(elig & ~own_oh));

  // Counts cycles of the current tenure; saturates so a lone owner keeps the bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tenure <= '0;
    end else if (grant_now || (state_nxt != ARB_BUSY)) begin
      tenure <= '0;
    end else if (tenure != TEN_LAST) begin
      tenure <= tenure + 1'b1;
    end
  end
`else
  logic [31:0] unused_max_tenure;
  assign unused_max_tenure = MAX_TENURE;
  assign revoke            = 1'b0;
`endif

  arb_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .MSEL_W      (MSEL_W)
  ) u_pick (
    .req   (pick_req),
    .start (rr_ptr),
    .mode  (ARB_MODE == ARB_RR),
    .vld   (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt         = state;
    msel_nxt          = msel;
    bgrant_nxt        = bgrant;
    msplit_nxt        = msplit;
    split_grant_nxt   = 1'b0;
    split_pending_nxt = split_pending;
    split_owner_nxt   = split_owner;
    rr_ptr_nxt        = rr_ptr;
    grant_now         = 1'b0;
    grant_idx         = msel;

    if (busy && ssplit && !split_pending) begin
      // Park the owner; this wins over a simultaneous request drop.
      split_owner_nxt       = msel;
      msplit_nxt            = '0;
      msplit_nxt[msel]      = 1'b1;
      split_pending_nxt     = 1'b1;
      bgrant_nxt            = '0;
      state_nxt             = ARB_IDLE;
    end else if (bus_free) begin
      if (!(&sready)) begin
        bgrant_nxt = '0;
        state_nxt  = ARB_IDLE;
      end else if (resume) begin
        // Resume beats every requester and does not need the owner's breq.
        grant_now         = 1'b1;
        grant_idx         = split_owner;
        split_grant_nxt   = 1'b1;
        msplit_nxt        = '0;
        split_pending_nxt = 1'b0;
      end else if (pick_vld) begin
        grant_now = 1'b1;
        grant_idx = pick_idx;
      end else begin
        bgrant_nxt = '0;
        state_nxt  = ARB_IDLE;
      end
    end

    if (grant_now) begin
      state_nxt             = ARB_BUSY;
      msel_nxt              = grant_idx;
      bgrant_nxt            = '0;
      bgrant_nxt[grant_idx] = 1'b1;
      rr_ptr_nxt            = (int'(grant_idx) == NUM_MASTERS - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ARB_IDLE;
      msel          <= '0;
      bgrant        <= '0;
      msplit        <= '0;
      split_grant   <= 1'b0;
      split_pending <= 1'b0;
      split_owner   <= '0;
      rr_ptr        <= '0;
    end else begin
      state         <= state_nxt;
      msel          <= msel_nxt;
      bgrant        <= bgrant_nxt;
      msplit        <= msplit_nxt;
      split_grant   <= split_grant_nxt;
      split_pending <= split_pending_nxt;
      split_owner   <= split_owner_nxt;
      rr_ptr        <= rr_ptr_nxt;
    end
  end

endmodule

// File: doc/arbiter_n.md
Name: arbiter_n

Overview:
- N-master bus arbiter with split-transaction support. It generalises the two-master arbiter to NUM_MASTERS requesters.
- Adds selectable fixed-priority or round-robin arbitration and a configurable count of non-split slaves.
- Sits between the master ports and the bus mux. It drives the one-hot grant, the mux select `msel`, the per-master split flags and the split-resume pulse.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (>=2); MSEL_W = max(1,$clog2(NUM_MASTERS)) as localparam.
- NUM_SLAVES, 2, number of non-split slaves whose ready bits gate new grants.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin.
- MAX_TENURE, 16, max consecutive grant cycles when ARB_TIMEOUT_EN is defined; ignored otherwise.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- breq  in  NUM_MASTERS  per-master bus request.
- sready  in  NUM_SLAVES  non-split slave ready bits.
- sreadysp  in  1  split-capable slave ready.
- ssplit  in  1  split-capable slave signals split of current transfer.
- bgrant  out  NUM_MASTERS  one-hot (or zero) registered grant.
- msel  out  MSEL_W  index of the granted master; holds last value when idle.
- msplit  out  NUM_MASTERS  sticky flag: master is parked on a split.
- split_grant  out  1  one-cycle pulse when a parked master is re-granted.

Behaviour:
- Reset (async, rstn=0): bgrant=0, msel=0, msplit=0, split_grant=0, state=IDLE, rr_ptr=0, split_pending=0, split_owner=0, tenure counter=0.
- All outputs are registered. A request sampled at edge k gives a grant visible after edge k+1 (one-cycle latency).
- States: IDLE (no grant) and BUSY (owner held in an index register).
- Eligible set = breq with the split_owner bit masked while split_pending=1.
- New grant condition: state is IDLE, or BUSY with breq[owner]=0. In both cases &sready must be 1; otherwise stay or go to IDLE with no grant.
- Resume has highest priority. If split_pending && sreadysp && !ssplit and the bus is free (as above), then on the same edge:
  - grant split_owner;
  - split_grant=1 for exactly one cycle;
  - msplit[split_owner]=0 and split_pending=0.
  - breq of the owner is not required.
- Otherwise pick from the eligible set:
  - Fixed mode: lowest set index.
  - Round robin: first set index at or above rr_ptr, wrapping modulo NUM_MASTERS. On every grant rr_ptr = granted index + 1, wrapping to 0.
- Direct handover: if the owner drops breq while another master is eligible, the new grant appears on that edge with no idle bubble.
- BUSY and ssplit=1 with split_pending=0:
  - split_owner=owner, msplit[owner]=1, split_pending=1;
  - bgrant=0, next state IDLE.
  - This takes priority over a simultaneous breq drop.
- ssplit=1 while split_pending=1 is ignored; only one split is outstanding.
- Invariants: popcount(bgrant) <= 1; msel equals the index of any set bgrant bit; msplit has at most one bit set.
- No requests and no resumable split: IDLE, bgrant=0.
- Reset mid-transfer or mid-split: all state is discarded and the parked master loses its split.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - The tenure counter increments each BUSY cycle and clears on a grant change.
  - When the count reaches MAX_TENURE-1 and another master is eligible, the grant is revoked at the next edge and re-arbitrated, with the current owner excluded for that decision.
  - The resumed split owner is also subject to the counter.
  - With no other requester the counter saturates and the grant is held.
- ARB_TIMEOUT_EN undefined: no counter; the owner holds the grant until breq drops or a split occurs.

Decomposition:
- Package arbiter_n_pkg holds:
  - the state enum (ARB_IDLE, ARB_BUSY);
  - mode constants ARB_FIXED=0 and ARB_RR=1;
  - a function for the MSEL_W computation.
- One natural sub-module: arb_pick, a combinational picker. Inputs: request vector, start pointer, mode. Outputs: valid and index. It is instantiated once.

Test Plan:
- Reset test: after reset, raise breq=4'b0110 with NUM_MASTERS=4, ARB_MODE=0, all ready → bgrant=4'b0010, msel=1 after one edge; drop breq[1] → bgrant=4'b0100, msel=2 on the next edge.
- Round robin: ARB_MODE=1, breq=4'b1111 held, each owner drops then re-raises breq for one cycle → grants rotate 0,1,2,3,0 in order.
- Split and resume:
  - Master 2 granted, ssplit=1 → next edge bgrant=0, msplit=4'b0100.
  - Master 0 requests with sreadysp=0 → granted.
  - Master 0 releases, then sreadysp=1, ssplit=0 → bgrant=4'b0100, split_grant=1 for one cycle, msplit=0.
- Ready gating: sready=2'b01 with breq=4'b0001 → no grant; set sready=2'b11 → grant master 0 on the next edge.
- Randomised invariants: 500 random cycles → bgrant never has more than one bit set, msel matches the granted index, msplit has at most one bit set.
- ARB_TIMEOUT_EN with MAX_TENURE=4: master 0 holds breq and master 1 requests → master 1 granted after exactly 4 cycles of master-0 tenure.
